// File: rtl/csi_cfg_pkg.sv
// Shared types and constants for the CSI TX register-block configuration master.
package csi_cfg_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_SLVERR  = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_WDOG    = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_PGAP = 3'd3,
    S_RSP  = 3'd4
  } state_e;

  // Byte offsets of the CSI TX register block
  localparam logic [7:0] REG_CR  = 8'h00;
  localparam logic [7:0] REG_ISR = 8'h04;
  localparam logic [7:0] REG_IER = 8'h08;
  localparam logic [7:0] REG_TR1 = 8'h0C;
  localparam logic [7:0] REG_TR2 = 8'h10;

endpackage

// File: rtl/csi_cfg_master.sv
// Avalon-MM initiator executing WRITE/READ/POLL commands against the CSI TX register block.
// Optional build macro CFG_WDOG_EN adds a waitrequest watchdog (WDOG_CYCLES).
module csi_cfg_master
  import csi_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int POLL_CNT_W  = 16,
  parameter int POLL_GAP    = 4,
  parameter int WDOG_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  input  logic [3:0]            cmd_byteenable,
  input  logic [POLL_CNT_W-1:0] poll_limit,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_status,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] avl_mm_addr,
  output logic                  avl_mm_read,
  input  logic [DATA_WIDTH-1:0] avl_mm_readdata,
  input  logic [1:0]            avl_mm_response,
  output logic                  avl_mm_write,
  output logic [DATA_WIDTH-1:0] avl_mm_writedata,
  output logic [3:0]            avl_mm_byteenable,
  input  logic                  avl_mm_waitrequest
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  if (POLL_GAP < 1 || WDOG_CYCLES < 1) begin : g_bad_param
    $error("csi_cfg_master: POLL_GAP and WDOG_CYCLES must be >= 1");
  end

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  status_e               status_q, status_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [3:0]            be_q, be_d;
  logic [POLL_CNT_W-1:0] limit_q, limit_d;
  logic [POLL_CNT_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;

`ifdef CFG_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    status_d   = status_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    be_d       = be_q;
    limit_d    = limit_q;
    poll_cnt_d = poll_cnt_q;
    rsp_data_d = rsp_data_q;
    gap_cnt_d  = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = op_e'(cmd_op);
          addr_d     = cmd_addr;
          data_d     = cmd_data;
          mask_d     = cmd_mask;
          be_d       = cmd_byteenable;
          limit_d    = poll_limit;
          poll_cnt_d = '0;
          rsp_data_d = '0;
          status_d   = ST_OK;
          state_d    = (op_e'(cmd_op) == OP_WRITE) ? S_WR : S_RD;
        end
      end
      S_WR: begin
        if (!avl_mm_waitrequest) begin
          status_d = (avl_mm_response != 2'b00) ? ST_SLVERR : ST_OK;
          state_d  = S_RSP;
        end
      end
      S_RD: begin
        if (!avl_mm_waitrequest) begin
          rsp_data_d = avl_mm_readdata;
          if (avl_mm_response != 2'b00) begin
            status_d = ST_SLVERR;
            state_d  = S_RSP;
          end else if (op_q != OP_POLL) begin
            status_d = ST_OK;
            state_d  = S_RSP;
          end else begin
            poll_cnt_d = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + POLL_CNT_W'(1);
            if ((avl_mm_readdata & mask_q) == (data_q & mask_q)) begin
              status_d = ST_OK;
              state_d  = S_RSP;
            end else if (limit_q != '0 && poll_cnt_d == limit_q) begin
              status_d = ST_TIMEOUT;
              state_d  = S_RSP;
            end else begin
              gap_cnt_d = '0;
              state_d   = S_PGAP;
            end
          end
        end
      end
      S_PGAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_RD;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef CFG_WDOG_EN
    // Consecutive stall cycles only; any completed beat or state change restarts the count.
    wdog_cnt_d = '0;
    if ((state_q == S_WR || state_q == S_RD) && avl_mm_waitrequest) begin
      if (wdog_cnt_q == WDOG_LAST) begin
        status_d = ST_WDOG;
        state_d  = S_RSP;
      end else begin
        wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_WRITE;
      status_q   <= ST_OK;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      be_q       <= '0;
      limit_q    <= '0;
      poll_cnt_q <= '0;
      rsp_data_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      status_q   <= status_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      be_q       <= be_d;
      limit_q    <= limit_d;
      poll_cnt_q <= poll_cnt_d;
      rsp_data_q <= rsp_data_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

`ifdef CFG_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
    end
  end
`endif

  // Requests decode straight from the state register so reset removes them immediately.
  always_comb begin
    cmd_ready         = (state_q == S_IDLE);
    busy              = (state_q != S_IDLE);
    rsp_valid         = (state_q == S_RSP);
    rsp_data          = rsp_data_q;
    rsp_status        = status_q;
    avl_mm_addr       = addr_q;
    avl_mm_write      = (state_q == S_WR);
    avl_mm_read       = (state_q == S_RD);
    avl_mm_writedata  = (state_q == S_WR) ? data_q : '0;
    avl_mm_byteenable = 4'h0;
    if (state_q == S_WR) begin
      avl_mm_byteenable = be_q;
    end else if (state_q == S_RD) begin
      avl_mm_byteenable = 4'hF;
    end
  end

endmodule

// File: tb/tb_csi_cfg_master.sv
// Directed self-checking bench for csi_cfg_master; the TB acts as the Avalon-MM slave.
// Honours CFG_WDOG_EN so the watchdog case matches the build under test.
module tb_csi_cfg_master;
  import csi_cfg_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [DW-1:0] cmd_mask;
  logic [3:0]    cmd_byteenable;
  logic [PW-1:0] poll_limit;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic          busy;
  logic [AW-1:0] avl_mm_addr;
  logic          avl_mm_read;
  logic [DW-1:0] avl_mm_readdata;
  logic [1:0]    avl_mm_response;
  logic          avl_mm_write;
  logic [DW-1:0] avl_mm_writedata;
  logic [3:0]    avl_mm_byteenable;
  logic          avl_mm_waitrequest;

  int total = 0;
  int bad   = 0;

  csi_cfg_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_CNT_W(PW), .POLL_GAP(4), .WDOG_CYCLES(255)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_byteenable(cmd_byteenable),
    .poll_limit(poll_limit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .busy(busy),
    .avl_mm_addr(avl_mm_addr), .avl_mm_read(avl_mm_read), .avl_mm_readdata(avl_mm_readdata),
    .avl_mm_response(avl_mm_response), .avl_mm_write(avl_mm_write),
    .avl_mm_writedata(avl_mm_writedata), .avl_mm_byteenable(avl_mm_byteenable),
    .avl_mm_waitrequest(avl_mm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Presents one command for exactly one accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [DW-1:0] mask,
                               input logic [3:0] be, input logic [PW-1:0] limit);
    @(negedge clk);
    checkOutput("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
    cmd_byteenable = be; poll_limit = limit; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Slave side of one transfer: stall for 'waits' edges, then complete with rdata/resp.
  task automatic serveXfer(input bit is_wr, input int waits, input logic [DW-1:0] rdata,
                           input logic [1:0] resp, input logic [AW-1:0] exp_addr,
                           input logic [DW-1:0] exp_wdata, input logic [3:0] exp_be,
                           output int idle, output int held);
    bit stable;
    idle = 0;
    held = 0;
    while (!(is_wr ? avl_mm_write : avl_mm_read) && idle < 1000) begin
      idle++;
      @(negedge clk);
    end
    if (idle >= 1000) begin
      checkOutput("req_timeout", 32'd0, 32'd1);
      return;
    end
    stable = 1'b1;
    for (int i = 0; i <= waits; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (is_wr ? avl_mm_write : avl_mm_read) held++;
      if (avl_mm_addr !== exp_addr || avl_mm_byteenable !== exp_be) stable = 1'b0;
      if ((is_wr ? avl_mm_read : avl_mm_write) !== 1'b0) stable = 1'b0;
      if (is_wr && avl_mm_writedata !== exp_wdata) stable = 1'b0;
    end
    checkOutput("req_stable", {31'd0, stable}, 32'd1);
    avl_mm_readdata = rdata;
    avl_mm_response = resp;
    avl_mm_waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    avl_mm_waitrequest = 1'b1;
    checkOutput("req_dropped", {30'd0, avl_mm_read, avl_mm_write}, 32'd0);
  endtask

  task automatic collectRsp(input logic [DW-1:0] exp_data, input logic [1:0] exp_status,
                            input int hold);
    int n;
    bit stable;
    n = 0;
    while (!rsp_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("rsp_data", rsp_data, exp_data);
    checkOutput("rsp_status", {30'd0, rsp_status}, {30'd0, exp_status});
    checkOutput("rsp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== exp_data || rsp_status !== exp_status ||
          cmd_ready || !busy) stable = 1'b0;
    end
    checkOutput("rsp_hold_stable", {31'd0, stable}, 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_released", {29'd0, rsp_valid, cmd_ready, busy}, 32'b010);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int idle, held, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
    cmd_mask = '0; cmd_byteenable = '0; poll_limit = '0; rsp_ready = 1'b0;
    avl_mm_readdata = '0; avl_mm_response = 2'b00; avl_mm_waitrequest = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("reset_ctrl", {27'd0, rsp_valid, busy, avl_mm_read, avl_mm_write, 1'b0}, 32'd0);
    checkOutput("reset_rsp", rsp_data | {30'd0, rsp_status}, 32'd0);
    checkOutput("reset_bus", avl_mm_writedata | {27'd0, avl_mm_addr} | {28'd0, avl_mm_byteenable}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] READ CR after reset");
    applyStimulus(OP_READ, AW'(REG_CR), 32'h0, 32'h0, 4'h0, 16'd0);
    serveXfer(1'b0, 1, 32'h0000_0300, 2'b00, AW'(REG_CR), 32'h0, 4'hF, idle, held);
    checkOutput("rd_latency", idle, 0);
    checkOutput("rd_held", held, 2);
    collectRsp(32'h0000_0300, ST_OK, 0);

    $display("[TB] WRITE TR1 with two stall cycles");
    applyStimulus(OP_WRITE, AW'(REG_TR1), 32'h0008_0F03, 32'h0, 4'hF, 16'd0);
    serveXfer(1'b1, 2, 32'hFFFF_FFFF, 2'b00, AW'(REG_TR1), 32'h0008_0F03, 4'hF, idle, held);
    checkOutput("wr_latency", idle, 0);
    checkOutput("wr_held", held, 3);
    collectRsp(32'h0, ST_OK, 0);

    $display("[TB] WRITE IER partial byteenable with slave error");
    applyStimulus(OP_WRITE, AW'(REG_IER), 32'h0000_005A, 32'h0, 4'h3, 16'd0);
    serveXfer(1'b1, 0, 32'h1234_5678, 2'b01, AW'(REG_IER), 32'h0000_005A, 4'h3, idle, held);
    checkOutput("wr_err_held", held, 1);
    collectRsp(32'h0, ST_SLVERR, 0);

    $display("[TB] POLL ISR bit1, unlimited, sets on third read");
    applyStimulus(OP_POLL, AW'(REG_ISR), 32'h2, 32'h2, 4'h0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      serveXfer(1'b0, 0, (i == 2) ? 32'h0000_0002 : 32'h0000_0001, 2'b00,
                AW'(REG_ISR), 32'h0, 4'hF, idle, held);
      checkOutput($sformatf("poll_gap%0d", i), idle, (i == 0) ? 0 : 4);
    end
    collectRsp(32'h0000_0002, ST_OK, 0);
    checkOutput("poll_no_extra_read", {31'd0, avl_mm_read}, 32'd0);

    $display("[TB] POLL limit 5, never matches");
    applyStimulus(OP_POLL, AW'(REG_ISR), 32'h2, 32'h2, 4'h0, 16'd5);
    for (int i = 0; i < 5; i++) begin
      serveXfer(1'b0, 0, (32'(i) << 4) | 32'h1, 2'b00, AW'(REG_ISR), 32'h0, 4'hF, idle, held);
      checkOutput($sformatf("poll_to_gap%0d", i), idle, (i == 0) ? 0 : 4);
    end
    collectRsp(32'h0000_0041, ST_TIMEOUT, 0);

    $display("[TB] POLL with zero mask matches first read");
    applyStimulus(OP_POLL, AW'(REG_TR2), 32'h0000_FFFF, 32'h0, 4'h0, 16'd3);
    serveXfer(1'b0, 0, 32'h0000_1234, 2'b00, AW'(REG_TR2), 32'h0, 4'hF, idle, held);
    collectRsp(32'h0000_1234, ST_OK, 0);

    $display("[TB] reserved opcode behaves as READ");
    applyStimulus(2'b11, AW'(REG_TR2), 32'h1, 32'hF, 4'h0, 16'd1);
    serveXfer(1'b0, 0, 32'h0000_CAFE, 2'b00, AW'(REG_TR2), 32'h0, 4'hF, idle, held);
    collectRsp(32'h0000_CAFE, ST_OK, 0);

    $display("[TB] READ slave error, response back-pressured");
    applyStimulus(OP_READ, AW'(REG_CR), 32'h0, 32'h0, 4'h0, 16'd0);
    serveXfer(1'b0, 0, 32'hDEAD_0001, 2'b10, AW'(REG_CR), 32'h0, 4'hF, idle, held);
    collectRsp(32'hDEAD_0001, ST_SLVERR, 10);

    $display("[TB] reset during pending read");
    applyStimulus(OP_READ, AW'(REG_IER), 32'h0, 32'h0, 4'h0, 16'd0);
    checkOutput("pre_reset_read", {31'd0, avl_mm_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_drop", {29'd0, avl_mm_read, busy, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_idle", {30'd0, rsp_valid, cmd_ready}, 32'b01);

    $display("[TB] waitrequest stuck high");
    applyStimulus(OP_READ, AW'(REG_CR), 32'h0, 32'h0, 4'h0, 16'd0);
    n = 0;
    while (avl_mm_read && n < 400) begin
      n++;
      @(negedge clk);
    end
`ifdef CFG_WDOG_EN
    checkOutput("wdog_cycles", n, 255);
    collectRsp(32'h0, ST_WDOG, 0);
`else
    checkOutput("no_wdog_held", n, 400);
    avl_mm_readdata = 32'h0000_0077;
    avl_mm_response = 2'b00;
    avl_mm_waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    avl_mm_waitrequest = 1'b1;
    collectRsp(32'h0000_0077, ST_OK, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csi_cfg_master.md
Name: csi_cfg_master

Overview:
Avalon-MM initiator that programs and monitors the CSI TX register block (CR/ISR/IER/TR1/TR2) from a command stream supplied by an on-chip sequencer or a debug bridge. It accepts WRITE, READ and POLL commands over a valid/ready interface and executes them as Avalon-MM transfers, honouring waitrequest. It returns one response per command with read data and status. It sits between the control sequencer and the register block's Avalon-MM slave port.

Parameters:
ADDR_WIDTH, 5, Avalon byte address width
DATA_WIDTH, 32, Avalon data width
POLL_CNT_W, 16, width of poll-attempt counter and poll_limit
POLL_GAP, 4, idle cycles between consecutive poll reads (>=1)
WDOG_CYCLES, 255, waitrequest watchdog limit (used only with CFG_WDOG_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 WRITE, 01 READ, 10 POLL, 11 reserved (treated as READ)
cmd_addr  in  ADDR_WIDTH  target register byte address
cmd_data  in  DATA_WIDTH  write data / POLL expected value
cmd_mask  in  DATA_WIDTH  POLL compare mask
cmd_byteenable  in  4  WRITE byte enables
poll_limit  in  POLL_CNT_W  max POLL reads; 0 = unlimited
rsp_valid  out  1  response held until rsp_ready
rsp_ready  in  1  response consumed
rsp_data  out  DATA_WIDTH  last read data (0 for WRITE)
rsp_status  out  2  00 OK, 01 slave error, 10 poll timeout, 11 watchdog
busy  out  1  high from acceptance until response consumed
avl_mm_addr  out  ADDR_WIDTH  address
avl_mm_read  out  1  read request
avl_mm_readdata  in  DATA_WIDTH  read data
avl_mm_response  in  2  00 OK, else error
avl_mm_write  out  1  write request
avl_mm_writedata  out  DATA_WIDTH  write data
avl_mm_byteenable  out  4  byte enables
avl_mm_waitrequest  in  1  slave stall

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; state IDLE; internal command registers cleared.
- States: IDLE, WR, RD, PGAP, RSP.
- IDLE: cmd_ready=1. On cmd_valid: latch cmd into registers; go WR (op 00) or RD (else); clear poll counter. Avalon request asserted the cycle after acceptance.
- WR: avl_mm_write=1, addr/writedata/byteenable from latched cmd, byteenable=cmd_byteenable. Held stable while waitrequest=1. Completes in the cycle write&!waitrequest; status = (response!=0) ? 01 : 00; go RSP.
- RD: avl_mm_read=1, byteenable=4'hF, held while waitrequest=1. On read&!waitrequest capture readdata into rsp_data.
  - response!=0 -> status 01, RSP (POLL aborts too).
  - READ -> status 00, RSP.
  - POLL: poll counter +1 (saturating). If (readdata & mask)==(data & mask) -> status 00, RSP. Else if poll_limit!=0 and counter==poll_limit -> status 10, RSP. Else PGAP.
- PGAP: requests low for POLL_GAP cycles, then RD.
- RSP: rsp_valid=1, cmd_ready=0, outputs stable until rsp_ready; on rsp_valid&rsp_ready go IDLE (next cmd acceptable the following cycle; no same-cycle accept).
- Never assert read and write together; at most one outstanding transfer.
- poll_limit sampled at acceptance.
- Mask 0 in POLL: first successful read matches.
- Reset mid-transfer: requests drop asynchronously; no response issued.

Optional Feature:
CFG_WDOG_EN: defined -> counter of consecutive waitrequest cycles in WR/RD; on reaching WDOG_CYCLES the request is dropped the next cycle, status 11, RSP. Not defined -> counter absent; master waits indefinitely on waitrequest.

Decomposition:
- Package csi_cfg_pkg: op codes (OP_WRITE, OP_READ, OP_POLL), status codes (ST_OK, ST_SLVERR, ST_TIMEOUT, ST_WDOG), CSI register offsets (CR 0x00, ISR 0x04, IER 0x08, TR1 0x0C, TR2 0x10).
- Single module; no sub-module needed.

Test Plan:
- WRITE 0x0C data 0x00080F03, be F, slave waitrequest 2 cycles -> write held stable 3 cycles, status 00, rsp_data 0.
- READ 0x00 after reset, slave returns 0x00000300 -> rsp_data 0x300, status 00, read high until !waitrequest.
- POLL 0x04 mask 0x2 data 0x2, limit 0, bit1 sets on 3rd read -> exactly 3 reads separated by 4 idle cycles, status 00.
- POLL limit 5, bit never sets -> 5 reads, status 10, rsp_data = last read value.
- READ with avl_mm_response=2'b10 -> status 01; rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, cmd_ready 0.
- CFG_WDOG_EN with waitrequest stuck high -> request dropped after 255 cycles, status 11; without macro -> request held indefinitely.
